// File: rtl/biriscv_csr_hpm_if.sv
// CSR access bundle for the counter bank: a read port used at issue and a write port used at writeback.
interface biriscv_csr_hpm_if;
  logic        csr_ren;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_hit;
  logic        csr_fault;
  logic        csr_write;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;

  modport master (output csr_ren, csr_raddr, csr_write, csr_waddr, csr_wdata,
                  input  csr_rdata, csr_hit, csr_fault);
  modport slave  (input  csr_ren, csr_raddr, csr_write, csr_waddr, csr_wdata,
                  output csr_rdata, csr_hit, csr_fault);
endinterface

// File: rtl/biriscv_csr_hpm.sv
// Machine counter / HPM CSR bank: mcycle, minstret, event counters, selectors, inhibit,
// counteren and an overflow status/enable pair that raises a registered interrupt.

// One wrapping counter. A write to either half blocks that cycle's increment.
module biriscv_csr_hpm_ctr #(
  parameter int W = 40
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [1:0]   inc_i,
  input  logic         wr_lo_i,
  input  logic         wr_hi_i,
  input  logic [31:0]  wdata_i,
  output logic [W-1:0] value_o,
  output logic         ovf_o
);
  logic [W:0] sum;

  assign sum   = {1'b0, value_o} + (W+1)'(inc_i);
  assign ovf_o = sum[W] & ~(wr_lo_i | wr_hi_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) value_o <= '0;
    else if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) value_o[31:0]   <= wdata_i;
      if (wr_hi_i) value_o[W-1:32] <= wdata_i[W-33:0];
    end else value_o <= sum[W-1:0];
  end
endmodule

module biriscv_csr_hpm #(
  parameter int NUM_COUNTERS = 4,
  parameter int COUNTER_W    = 40,
  parameter int NUM_EVENTS   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic [1:0]            instret_i,
  input  logic [1:0]            priv_i,
  biriscv_csr_hpm_if.slave      csr,
  output logic                  ovf_irq_o
);
  // Lane 0 = mcycle, lane 1 = minstret, lane 2+i = mhpmcounter(3+i)
  localparam int         NT     = NUM_COUNTERS + 2;
  localparam logic [1:0] PRIV_M = 2'd3;

  // CSR bit index (and address offset) owned by a lane
  function automatic int lane_bit(int l);
    return (l == 0) ? 0 : l + 1;
  endfunction

  function automatic logic [31:0] impl_mask();
    logic [31:0] m = '0;
    for (int l = 0; l < NT; l++) m[5'(lane_bit(l))] = 1'b1;
    return m;
  endfunction

  localparam logic [31:0] IMPL = impl_mask();

  logic [31:0]                   inhibit_q, counteren_q, ovf_q, ovf_en_q;
  logic [NUM_COUNTERS-1:0][4:0]  evt_q;
  logic [NT-1:0][COUNTER_W-1:0]  cnt;
  logic [NT-1:0][1:0]            inc;
  logic [NT-1:0]                 wr_lo, wr_hi, lane_ovf;
  logic [31:0]                   ev_ext, new_ovf;
  logic [31:0]                   rd_data;
  logic                          rd_hit, rd_shadow, rd_cen, rd_fault;

  assign ev_ext = 32'(event_i);

  always_comb begin
    inc    = '0;
    inc[0] = inhibit_q[0] ? 2'd0 : 2'd1;
    inc[1] = inhibit_q[2] ? 2'd0 : instret_i;
    for (int i = 0; i < NUM_COUNTERS; i++)
      if (!inhibit_q[5'(3 + i)] && evt_q[i] != 5'd0 && 32'(evt_q[i]) <= NUM_EVENTS &&
          ev_ext[evt_q[i] - 5'd1])
        inc[2 + i] = 2'd1;
  end

  for (genvar l = 0; l < NT; l++) begin : g_lane
    localparam int B = (l == 0) ? 0 : l + 1;
    assign wr_lo[l] = csr.csr_write && (csr.csr_waddr == 12'(12'hB00 + B));
    assign wr_hi[l] = csr.csr_write && (csr.csr_waddr == 12'(12'hB80 + B));

    biriscv_csr_hpm_ctr #(.W(COUNTER_W)) u_ctr (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (inc[l]),
      .wr_lo_i (wr_lo[l]),
      .wr_hi_i (wr_hi[l]),
      .wdata_i (csr.csr_wdata),
      .value_o (cnt[l]),
      .ovf_o   (lane_ovf[l])
    );
  end

  always_comb begin
    new_ovf = '0;
    for (int l = 0; l < NT; l++) new_ovf[5'(lane_bit(l))] = lane_ovf[l];
  end

  // Fresh overflow ORs on top of a SW write so a same-cycle wrap is never lost
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inhibit_q   <= '0;
      counteren_q <= '0;
      ovf_q       <= '0;
      ovf_en_q    <= '0;
      evt_q       <= '0;
      ovf_irq_o   <= 1'b0;
    end else begin
      if (csr.csr_write) begin
        case (csr.csr_waddr)
          12'h320: inhibit_q   <= csr.csr_wdata & IMPL;
          12'h306: counteren_q <= csr.csr_wdata & IMPL;
          12'h7C1: ovf_en_q    <= csr.csr_wdata & IMPL;
          default: ;
        endcase
        for (int i = 0; i < NUM_COUNTERS; i++)
          if (csr.csr_waddr == 12'(12'h323 + i)) evt_q[i] <= csr.csr_wdata[4:0];
      end
      ovf_q <= ((csr.csr_write && csr.csr_waddr == 12'h7C0) ? (csr.csr_wdata & IMPL) : ovf_q)
               | new_ovf;
      ovf_irq_o <= |(ovf_q & ovf_en_q);
    end
  end

  always_comb begin
    rd_hit    = 1'b0;
    rd_data   = '0;
    rd_shadow = 1'b0;
    rd_cen    = 1'b0;
    for (int l = 0; l < NT; l++) begin
      if (csr.csr_raddr == 12'(12'hB00 + lane_bit(l)) ||
          csr.csr_raddr == 12'(12'hC00 + lane_bit(l))) begin
        rd_hit  = 1'b1;
        rd_data = cnt[l][31:0];
      end
      if (csr.csr_raddr == 12'(12'hB80 + lane_bit(l)) ||
          csr.csr_raddr == 12'(12'hC80 + lane_bit(l))) begin
        rd_hit  = 1'b1;
        rd_data = 32'(cnt[l][COUNTER_W-1:32]);
      end
      if (csr.csr_raddr[11:8] == 4'hC && csr.csr_raddr[6:0] == 7'(lane_bit(l))) begin
        rd_shadow = 1'b1;
        rd_cen    = counteren_q[5'(lane_bit(l))];
      end
    end
    for (int i = 0; i < NUM_COUNTERS; i++)
      if (csr.csr_raddr == 12'(12'h323 + i)) begin
        rd_hit  = 1'b1;
        rd_data = 32'(evt_q[i]);
      end
    case (csr.csr_raddr)
      12'h320: begin rd_hit = 1'b1; rd_data = inhibit_q;   end
      12'h306: begin rd_hit = 1'b1; rd_data = counteren_q; end
      12'h7C0: begin rd_hit = 1'b1; rd_data = ovf_q;       end
      12'h7C1: begin rd_hit = 1'b1; rd_data = ovf_en_q;    end
      default: ;
    endcase
    // Below M: machine CSRs always fault, user shadows only when not enabled
    rd_fault = rd_hit && (priv_i < PRIV_M) && (!rd_shadow || !rd_cen);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      csr.csr_rdata <= '0;
      csr.csr_hit   <= 1'b0;
      csr.csr_fault <= 1'b0;
    end else if (csr.csr_ren) begin
      csr.csr_rdata <= rd_fault ? 32'd0 : rd_data;
      csr.csr_hit   <= rd_hit;
      csr.csr_fault <= rd_fault;
    end else begin
      csr.csr_rdata <= '0;
      csr.csr_hit   <= 1'b0;
      csr.csr_fault <= 1'b0;
    end
  end
endmodule

// File: tb/tb_biriscv_csr_hpm.sv
// Random + directed bench for biriscv_csr_hpm against a per-cycle behavioural model of the counter bank.
module tb_biriscv_csr_hpm;
  localparam int NC = 4, CW = 40, NE = 8;
  localparam bit [63:0] CMASK = (64'd1 << CW) - 64'd1;

  logic          clk_i = 1'b0, rst_i = 1'b1;
  logic [NE-1:0] event_i = '0;
  logic [1:0]    instret_i = '0, priv_i = 2'd3;
  logic          ovf_irq_o;

  biriscv_csr_hpm_if csr_if();

  biriscv_csr_hpm #(.NUM_COUNTERS(NC), .COUNTER_W(CW), .NUM_EVENTS(NE)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .event_i   (event_i),
    .instret_i (instret_i),
    .priv_i    (priv_i),
    .csr       (csr_if),
    .ovf_irq_o (ovf_irq_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model state indexed by CSR bit k (0=cycle, 2=instret, 3+i=hpm i)
  bit [63:0] m_cnt[32];
  bit [4:0]  m_evt[NC];
  bit [31:0] m_inh, m_cen, m_ovf, m_oen;
  bit        m_irq;

  function automatic bit impl(input int k);
    return k == 0 || k == 2 || (k >= 3 && k < 3 + NC);
  endfunction

  function automatic bit [31:0] impl_bits();
    bit [31:0] m = '0;
    for (int k = 0; k < 32; k++) m[k] = impl(k);
    return m;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 32; k++) m_cnt[k] = '0;
    for (int i = 0; i < NC; i++) m_evt[i] = '0;
    m_inh = '0; m_cen = '0; m_ovf = '0; m_oen = '0; m_irq = 1'b0;
  endtask

  task automatic m_read(input bit [11:0] a, input bit [1:0] p,
                        output bit [31:0] d, output bit h, output bit f);
    int k;
    d = '0; h = 1'b0; f = 1'b0;
    k = int'(a[4:0]);
    if ((a[11:8] == 4'hB || a[11:8] == 4'hC) && a[6:5] == 2'b00 && impl(k)) begin
      h = 1'b1;
      d = a[7] ? 32'(m_cnt[k] >> 32) : m_cnt[k][31:0];
      f = (p < 2'd3) && (a[11:8] == 4'hB || !m_cen[k]);
    end else begin
      case (a)
        12'h320: begin h = 1'b1; d = m_inh; end
        12'h306: begin h = 1'b1; d = m_cen; end
        12'h7C0: begin h = 1'b1; d = m_ovf; end
        12'h7C1: begin h = 1'b1; d = m_oen; end
        default: ;
      endcase
      for (int i = 0; i < NC; i++)
        if (a == 12'(12'h323 + i)) begin h = 1'b1; d = 32'(m_evt[i]); end
      f = h && (p < 2'd3);
    end
    if (f) d = '0;
  endtask

  // One clock of model time, using the inputs currently driven
  task automatic m_tick();
    bit [31:0] nov = '0, wd;
    bit [11:0] a;
    bit        w, irq_n, wlo, whi;
    bit [63:0] s;
    bit [7:0]  ev;
    int        inc, sel;
    w = csr_if.csr_write; a = csr_if.csr_waddr; wd = csr_if.csr_wdata; ev = event_i;
    irq_n = |(m_ovf & m_oen);
    for (int k = 0; k < 32; k++) begin
      if (!impl(k)) continue;
      inc = 0;
      if (!m_inh[k]) begin
        if (k == 0) inc = 1;
        else if (k == 2) inc = int'(instret_i);
        else begin
          sel = int'(m_evt[k-3]);
          if (sel >= 1 && sel <= NE) inc = int'(ev[sel-1]);
        end
      end
      wlo = w && a == 12'(12'hB00 + k);
      whi = w && a == 12'(12'hB80 + k);
      if (wlo || whi) begin
        if (wlo) m_cnt[k] = (m_cnt[k] & ~64'hFFFF_FFFF) | 64'(wd);
        if (whi) m_cnt[k] = (m_cnt[k] & 64'hFFFF_FFFF) | ((64'(wd) << 32) & CMASK);
      end else begin
        s = m_cnt[k] + 64'(inc);
        if (s > CMASK) nov[k] = 1'b1;
        m_cnt[k] = s & CMASK;
      end
    end
    if (w) begin
      if (a == 12'h320) m_inh = wd & impl_bits();
      if (a == 12'h306) m_cen = wd & impl_bits();
      if (a == 12'h7C1) m_oen = wd & impl_bits();
      for (int i = 0; i < NC; i++) if (a == 12'(12'h323 + i)) m_evt[i] = wd[4:0];
    end
    m_ovf = ((w && a == 12'h7C0) ? (wd & impl_bits()) : m_ovf) | nov;
    m_irq = irq_n;
  endtask

  task automatic step();
    bit [31:0] ed;
    bit        eh, ef;
    if (csr_if.csr_ren) m_read(csr_if.csr_raddr, priv_i, ed, eh, ef);
    else begin ed = '0; eh = 1'b0; ef = 1'b0; end
    m_tick();
    @(posedge clk_i); #1;
    chk($sformatf("rdata@%0h", csr_if.csr_raddr), 64'(csr_if.csr_rdata), 64'(ed));
    chk("hit", 64'(csr_if.csr_hit), 64'(eh));
    chk("fault", 64'(csr_if.csr_fault), 64'(ef));
    chk("irq", 64'(ovf_irq_o), 64'(m_irq));
  endtask

  task automatic wr(input bit [11:0] a, input bit [31:0] d);
    csr_if.csr_write = 1'b1; csr_if.csr_waddr = a; csr_if.csr_wdata = d;
    step();
    csr_if.csr_write = 1'b0;
  endtask

  task automatic rd(input bit [11:0] a);
    csr_if.csr_ren = 1'b1; csr_if.csr_raddr = a;
    step();
    csr_if.csr_ren = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rdata"}, 64'(csr_if.csr_rdata), 64'd0);
    chk({tag, "_hit"},   64'(csr_if.csr_hit),   64'd0);
    chk({tag, "_fault"}, 64'(csr_if.csr_fault), 64'd0);
    chk({tag, "_irq"},   64'(ovf_irq_o),        64'd0);
  endtask

  bit [11:0] addrs[] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB04, 12'hB05, 12'hB06,
                         12'hB83, 12'hB86, 12'hC00, 12'hC80, 12'hC02, 12'hC03, 12'hC86, 12'h320,
                         12'h323, 12'h324, 12'h325, 12'h326, 12'h306, 12'h7C0, 12'h7C1, 12'hB01,
                         12'hB07, 12'h321, 12'hC01};

  function automatic bit [11:0] pick();
    if ($urandom_range(0, 9) == 0) return 12'($urandom);
    return addrs[$urandom_range(0, addrs.size() - 1)];
  endfunction

  function automatic bit [31:0] pick_data(input bit [11:0] a);
    if (a >= 12'h323 && a <= 12'h326) return $urandom_range(0, 10);
    if (a == 12'h320) return ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
    case ($urandom_range(0, 3))
      0: return 32'hFFFF_FFFF;
      1: return 32'hFFFF_FFFE;
      2: return 32'h0000_00FF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    csr_if.csr_ren = 1'b0; csr_if.csr_raddr = '0;
    csr_if.csr_write = 1'b0; csr_if.csr_waddr = '0; csr_if.csr_wdata = '0;
    m_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk_idle("reset");
    rst_i = 1'b0;

    // idle count, then minstret untouched
    repeat (10) step();
    rd(12'hB00); chk("t1_mcycle", 64'(csr_if.csr_rdata), 64'd10);
    rd(12'hB02); chk("t1_minstret", 64'(csr_if.csr_rdata), 64'd0);

    // dual retire, then inhibited retire
    instret_i = 2'd2;
    repeat (4) step();
    wr(12'h320, 32'h4);
    repeat (3) step();
    instret_i = 2'd0;
    wr(12'h320, 32'h0);
    rd(12'hB02); chk("t2_minstret", 64'(csr_if.csr_rdata), 64'd10);

    // selector 4 counts event_i[3] only
    wr(12'h323, 32'd4);
    event_i = 8'h08; repeat (7) step();
    event_i = 8'h04; repeat (5) step();
    event_i = 8'h00;
    rd(12'hB03); chk("t3_hpm3", 64'(csr_if.csr_rdata), 64'd7);

    // mcycle wrap -> ovf[0] -> irq
    wr(12'h7C1, 32'h1);
    wr(12'hB80, 32'hFF);
    wr(12'hB00, 32'hFFFF_FFFE);
    step(); step();
    rd(12'h7C0);
    chk("t4_ovf", 64'(csr_if.csr_rdata), 64'd1);
    chk("t4_irq", 64'(ovf_irq_o), 64'd1);
    wr(12'h7C0, 32'h0);
    wr(12'h7C1, 32'h0);

    // user shadow access gated by mcounteren
    priv_i = 2'd0;
    rd(12'hC00);
    chk("t5_fault", 64'(csr_if.csr_fault), 64'd1);
    chk("t5_rdata", 64'(csr_if.csr_rdata), 64'd0);
    priv_i = 2'd3;
    wr(12'h306, 32'h1);
    priv_i = 2'd0;
    rd(12'hC00);
    chk("t5_ok_fault", 64'(csr_if.csr_fault), 64'd0);
    chk("t5_ok_hit", 64'(csr_if.csr_hit), 64'd1);
    priv_i = 2'd3;

    // write beats same-cycle event
    event_i = 8'h08;
    wr(12'hB03, 32'h1234);
    event_i = 8'h00;
    rd(12'hB03); chk("t6_hpm3", 64'(csr_if.csr_rdata), 64'h1234);

    for (int n = 0; n < 800; n++) begin
      if (n == 400) begin
        csr_if.csr_ren = 1'b0; csr_if.csr_write = 1'b0; event_i = '0; instret_i = '0;
        priv_i = 2'd3;
        rst_i = 1'b1; #2;
        chk_idle("midrst");
        m_reset();
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        step();
        rd(12'hB00); chk("rst_resume", 64'(csr_if.csr_rdata), 64'd1);
      end
      event_i   = 8'($urandom);
      instret_i = 2'($urandom_range(0, 2));
      priv_i    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'd3;
      csr_if.csr_ren   = 1'($urandom_range(0, 1));
      csr_if.csr_raddr = pick();
      csr_if.csr_write = ($urandom_range(0, 3) == 0);
      csr_if.csr_waddr = pick();
      csr_if.csr_wdata = pick_data(csr_if.csr_waddr);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
